led_glow_multi: RTL and testbench

Multi-channel LED glow (breathing) driver, the parametrised successor to the single-channel glow block. It generates one PWM output per channel from a shared prescaler and PWM counter. Each channel's duty follows a triangle ramp, with a static phase offset so the channels breathe out of step. Each channel has its own run-time mode (off/on/breathe/blink), and the block has a global enable. It sits directly between the system clock and the board LED pins.

---
 rtl/led_glow_multi.sv | 134 +++++++++++++
 tb/tb_led_glow_multi.sv | 129 ++++++++++++
 2 files changed

// File: rtl/led_glow_multi.sv
// Multi-channel LED breathing driver: shared prescaler/PWM counter, per-channel
// phase-staggered triangle duty and run-time mode. Define GAMMA_EN for squared-law BREATHE.
module led_glow_multi #(
    parameter int N_CH         = 4,
    parameter int PWM_W        = 8,
    parameter int PRESCALE     = 16,
    parameter int STEP_PERIODS = 4,
    parameter int PHASE_SPREAD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   led,
    output logic              period_tick
);

    localparam int MAX  = (1 << PWM_W) - 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int ST_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [PWM_W-1:0] MAX_V  = PWM_W'(MAX);
    localparam logic [PS_W-1:0]  PS_TOP = PS_W'(PRESCALE - 1);
    localparam logic [ST_W-1:0]  ST_TOP = ST_W'(STEP_PERIODS - 1);

    localparam logic [1:0] M_OFF     = 2'b00;
    localparam logic [1:0] M_ON      = 2'b01;
    localparam logic [1:0] M_BREATHE = 2'b10;
    localparam logic [1:0] M_BLINK   = 2'b11;

    logic [PS_W-1:0]   presc;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [ST_W-1:0]   step_cnt;
    logic [2*N_CH-1:0] mode_q;
    logic [PWM_W-1:0]  duty [N_CH];
    logic              dir_up [N_CH];

    logic presc_wrap;
    logic pwm_wrap;
    logic period_wrap;
    logic step_wrap;

    // Channel i starts at position (i*2*MAX)/N_CH along the 2*MAX-step triangle.
    function automatic int start_pos(input int i);
        if (PHASE_SPREAD == 0)
            return 0;
        return (i * 2 * MAX) / N_CH;
    endfunction

    function automatic logic [PWM_W-1:0] start_duty(input int i);
        int p;
        p = start_pos(i);
        if (p < MAX)
            return PWM_W'(p);
        return PWM_W'(2 * MAX - p);
    endfunction

    function automatic logic start_up(input int i);
        return (start_pos(i) < MAX);
    endfunction

    function automatic logic [PWM_W-1:0] shape(input logic [PWM_W-1:0] d);
`ifdef GAMMA_EN
        logic [2*PWM_W-1:0] sq;
        sq = {{PWM_W{1'b0}}, d} * {{PWM_W{1'b0}}, d} + (2*PWM_W)'(MAX);
        return PWM_W'(sq >> PWM_W);
`else
        return d;
`endif
    endfunction

    assign presc_wrap  = (presc == PS_TOP);
    assign pwm_wrap    = (pwm_cnt == MAX_V - 1'b1);
    assign period_wrap = presc_wrap && pwm_wrap;
    assign step_wrap   = (step_cnt == ST_TOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            pwm_cnt     <= '0;
            step_cnt    <= '0;
            mode_q      <= '0;
            led         <= '0;
            period_tick <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty[i]   <= start_duty(i);
                dir_up[i] <= start_up(i);
            end
        end else if (!en) begin
            led         <= '0;
            period_tick <= 1'b0;
        end else begin
            presc       <= presc_wrap ? '0 : presc + 1'b1;
            period_tick <= period_wrap;
            if (presc_wrap)
                pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + 1'b1;

            // Mode and ramp only move at a period boundary, so outputs never runt.
            if (period_wrap) begin
                mode_q   <= mode;
                step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;
                if (step_wrap) begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (dir_up[i]) begin
                            if (duty[i] == MAX_V) begin
                                dir_up[i] <= 1'b0;
                                duty[i]   <= MAX_V - 1'b1;
                            end else begin
                                duty[i] <= duty[i] + 1'b1;
                            end
                        end else begin
                            if (duty[i] == '0) begin
                                dir_up[i] <= 1'b1;
                                duty[i]   <= PWM_W'(1);
                            end else begin
                                duty[i] <= duty[i] - 1'b1;
                            end
                        end
                    end
                end
            end

            for (int i = 0; i < N_CH; i++) begin
                case (mode_q[2*i +: 2])
                    M_OFF:     led[i] <= 1'b0;
                    M_ON:      led[i] <= 1'b1;
                    M_BREATHE: led[i] <= (pwm_cnt < shape(duty[i]));
                    M_BLINK:   led[i] <= dir_up[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_glow_multi.sv
// Randomized bench for led_glow_multi against a position-in-time reference model.
module tb_led_glow_multi;

    localparam int N_CH         = 4;
    localparam int PWM_W        = 3;
    localparam int PRESCALE     = 2;
    localparam int STEP_PERIODS = 1;
    localparam int PHASE_SPREAD = 1;
    localparam int MAX          = (1 << PWM_W) - 1;
    localparam int PER          = PRESCALE * MAX;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              en   = 1'b0;
    logic [2*N_CH-1:0] mode = '0;
    logic [N_CH-1:0]   led;
    logic              period_tick;

    int checks = 0;
    int errors = 0;

    int                ecount  = 0;
    logic [2*N_CH-1:0] mq      = '0;
    logic [N_CH-1:0]   exp_led = '0;
    logic              exp_tick = 1'b0;

    always #5 clk = ~clk;

    led_glow_multi #(
        .N_CH(N_CH), .PWM_W(PWM_W), .PRESCALE(PRESCALE),
        .STEP_PERIODS(STEP_PERIODS), .PHASE_SPREAD(PHASE_SPREAD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .led(led), .period_tick(period_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference: everything follows from the number of enabled clocks since reset.
    task automatic model_edge();
        int pos, pwm, s, p, ph, d;
        logic up;
        if (rst) begin
            ecount   = 0;
            mq       = '0;
            exp_led  = '0;
            exp_tick = 1'b0;
        end else if (!en) begin
            exp_led  = '0;
            exp_tick = 1'b0;
        end else begin
            pos = ecount % PER;
            pwm = pos / PRESCALE;
            s   = (ecount / PER) / STEP_PERIODS;
            for (int i = 0; i < N_CH; i++) begin
                p  = (PHASE_SPREAD != 0) ? (i * 2 * MAX) / N_CH : 0;
                ph = (p + s) % (2 * MAX);
                d  = (ph <= MAX) ? ph : 2 * MAX - ph;
                up = (s == 0) ? (p < MAX) : (ph >= 1 && ph <= MAX);
`ifdef GAMMA_EN
                d = (d * d + MAX) >> PWM_W;
`endif
                case (mq[2*i +: 2])
                    2'b00: exp_led[i] = 1'b0;
                    2'b01: exp_led[i] = 1'b1;
                    2'b10: exp_led[i] = (pwm < d);
                    2'b11: exp_led[i] = up;
                endcase
            end
            exp_tick = (pos == PER - 1);
            if (exp_tick)
                mq = mode;
            ecount++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("led", 32'(led), 32'(exp_led));
            chk("period_tick", 32'(period_tick), 32'(exp_tick));
        end
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; en = 1'b1; mode = '0;
        run(3);
        rst = 1'b0; mode = {N_CH{2'b01}};
        run(PER * 2);
        mode = '0;
        run(PER + 5);
        mode = {N_CH{2'b10}};
        run(PER * 16);
        mode = {N_CH{2'b11}};
        run(PER * 16);
        mode = {2'b10, 2'b11, 2'b10, 2'b01};
        run(5);
        en = 1'b0;
        run(20);
        en = 1'b1;
        run(PER * 2);
        rst = 1'b1;
        run(1);
        rst = 1'b0; mode = {N_CH{2'b10}};
        run(PER * 3);
        for (int k = 0; k < 60; k++) begin
            r    = $urandom;
            mode = r[2*N_CH-1:0];
            en   = ($urandom_range(0, 7) != 0);
            rst  = ($urandom_range(0, 29) == 0);
            run($urandom_range(1, 40));
            rst  = 1'b0;
        end
        en = 1'b1;
        run(PER * 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
